reaper_exec_ctrl: RTL and testbench

//  Execute/decode slice of the Reaper 32-bit core in one block: clock divider (Slow_Clock),
//  6-bit opcode decoder driving datapath control lines, and 32-bit signed ALU. Decoder and
//  ALU are combinational; only the divider holds state. Feeds PC, regfile, RAM, stack, IO.

---
 rtl/reaper_exec_ctrl_if.sv | 46 ++++
 rtl/reaper_exec_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_reaper_exec_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reaper_exec_ctrl_if.sv
// Reaper execute/decode slice: opcode, operand and control bundle.
// master drives opcode/operands, slave returns decode and ALU results.
interface reaper_exec_ctrl_if;
  logic [5:0]  Opcode;
  logic [31:0] Input_1;
  logic [31:0] Input_2;
  logic [31:0] Result;
  logic        True;
  logic [4:0]  ALU_Op;
  logic        Reg_Write;
  logic        ALU_Src;
  logic        Long_Imm;
  logic        Mem_Write;
  logic        Mem_To_Reg;
  logic        Branch;
  logic        Jump_R;
  logic        Jump_I;
  logic        Stack_Enable;
  logic        Stack_Write;
  logic        IO_Enable;
  logic        IO_Selection;
  logic        Halt;
  logic        Change_Context;

  modport master (
    output Opcode, Input_1, Input_2,
    input  Result, True, ALU_Op,
    input  Reg_Write, ALU_Src, Long_Imm,
    input  Mem_Write, Mem_To_Reg, Branch,
    input  Jump_R, Jump_I, Stack_Enable,
    input  Stack_Write, IO_Enable,
    input  IO_Selection, Halt,
    input  Change_Context
  );

  modport slave (
    input  Opcode, Input_1, Input_2,
    output Result, True, ALU_Op,
    output Reg_Write, ALU_Src, Long_Imm,
    output Mem_Write, Mem_To_Reg, Branch,
    output Jump_R, Jump_I, Stack_Enable,
    output Stack_Write, IO_Enable,
    output IO_Selection, Halt,
    output Change_Context
  );
endinterface

// File: rtl/reaper_exec_ctrl.sv
// Reaper execute/decode slice: clock divider,
// opcode decoder and 32-bit signed ALU.
module reaper_exec_ctrl #(
  parameter int DIV = 2
) (
  input  logic Fast_Clock,
  input  logic Raw_Reset_I,
  output logic Slow_Clock,
  reaper_exec_ctrl_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          slow_q;

  // Divider: toggle Slow_Clock every DIV fast edges.
  always_ff @(posedge Fast_Clock or negedge Raw_Reset_I) begin
    if (!Raw_Reset_I) begin
      cnt    <= '0;
      slow_q <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      slow_q <= ~slow_q;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  assign Slow_Clock = slow_q;

  logic [5:0] op;
  logic [4:0] aop;
  logic rw, asrc, limm, mw, m2r, br;
  logic jr, ji, sen, swr, ioen, iosel;
  logic hlt, ctx;

  assign op = bus.Opcode;

  // Decoder: opcode to datapath controls; unknown = NOP.
  always_comb begin
    aop   = '0;
    rw    = 1'b0;
    asrc  = 1'b0;
    limm  = 1'b0;
    mw    = 1'b0;
    m2r   = 1'b0;
    br    = 1'b0;
    jr    = 1'b0;
    ji    = 1'b0;
    sen   = 1'b0;
    swr   = 1'b0;
    ioen  = 1'b0;
    iosel = 1'b0;
    hlt   = 1'b0;
    ctx   = 1'b0;
    unique case (1'b1)
      (op inside {[6'h01:6'h12]}): begin
        rw  = 1'b1;
        aop = 5'(op - 6'h01);
      end
      (op inside {[6'h21:6'h32]}): begin
        rw   = 1'b1;
        asrc = 1'b1;
        aop  = 5'(op - 6'h21);
      end
      (op == 6'h13): begin
        rw   = 1'b1;
        asrc = 1'b1;
        limm = 1'b1;
        aop  = 5'd18;
      end
      (op == 6'h14): begin
        rw   = 1'b1;
        asrc = 1'b1;
        m2r  = 1'b1;
      end
      (op == 6'h15): begin
        asrc = 1'b1;
        mw   = 1'b1;
      end
      (op == 6'h16): begin
        br  = 1'b1;
        aop = 5'd12;
      end
      (op == 6'h17): begin
        br  = 1'b1;
        aop = 5'd13;
      end
      (op == 6'h18): begin
        br  = 1'b1;
        aop = 5'd14;
      end
      (op == 6'h19): begin
        br  = 1'b1;
        aop = 5'd16;
      end
      (op == 6'h1A): jr = 1'b1;
      (op == 6'h1B): begin
        ji   = 1'b1;
        limm = 1'b1;
      end
      (op == 6'h1C): begin
        ji   = 1'b1;
        limm = 1'b1;
        sen  = 1'b1;
        swr  = 1'b1;
      end
      (op == 6'h1D): sen = 1'b1;
      (op == 6'h1E): begin
        ioen = 1'b1;
        rw   = 1'b1;
      end
      (op == 6'h1F): begin
        ioen  = 1'b1;
        iosel = 1'b1;
      end
      (op == 6'h20): ctx = 1'b1;
      (op == 6'h3F): hlt = 1'b1;
      default: ;
    endcase
  end

  logic [31:0] a, b, res;
  logic signed [31:0] sa, sb;
  logic tru;
  logic ovf;

  assign a   = bus.Input_1;
  assign b   = bus.Input_2;
  assign sa  = $signed(a);
  assign sb  = $signed(b);
  // The one signed quotient that does not fit in 32 bits.
  assign ovf = (a == 32'h8000_0000) &&
               (b == 32'hFFFF_FFFF);

  // ALU: signed arithmetic, logic, shifts and compares.
  always_comb begin
    res = '0;
    tru = 1'b0;
    case (aop)
      5'd0:  res = a + b;
      5'd1:  res = a - b;
      5'd2:  res = 32'(sa * sb);
      5'd3: begin
        if (b == '0)  res = '0;
        else if (ovf) res = 32'h8000_0000;
        else          res = 32'(sa / sb);
      end
      5'd4: begin
        if (b == '0 || ovf) res = '0;
        else                res = 32'(sa % sb);
      end
      5'd5:  res = a & b;
      5'd6:  res = a | b;
      5'd7:  res = a ^ b;
      5'd8:  res = ~a;
      5'd9:  res = a << b[4:0];
      5'd10: res = a >> b[4:0];
      5'd11: res = 32'(sa >>> b[4:0]);
      5'd12: tru = (a == b);
      5'd13: tru = (a != b);
      5'd14: tru = (sa < sb);
      5'd15: tru = (sa <= sb);
      5'd16: tru = (sa > sb);
      5'd17: tru = (sa >= sb);
      5'd18: res = b;
      default: res = '0;
    endcase
    if (aop inside {[5'd12:5'd17]})
      res = {31'b0, tru};
  end

  assign bus.Result         = res;
  assign bus.True           = tru;
  assign bus.ALU_Op         = aop;
  assign bus.Reg_Write      = rw;
  assign bus.ALU_Src        = asrc;
  assign bus.Long_Imm       = limm;
  assign bus.Mem_Write      = mw;
  assign bus.Mem_To_Reg     = m2r;
  assign bus.Branch         = br;
  assign bus.Jump_R         = jr;
  assign bus.Jump_I         = ji;
  assign bus.Stack_Enable   = sen;
  assign bus.Stack_Write    = swr;
  assign bus.IO_Enable      = ioen;
  assign bus.IO_Selection   = iosel;
  assign bus.Halt           = hlt;
  assign bus.Change_Context = ctx;

endmodule

// File: tb/tb_reaper_exec_ctrl.sv
// Bench for reaper_exec_ctrl: divider timing plus
// random decode/ALU traffic against a reference model.
module tb_reaper_exec_ctrl;

  localparam int DIV = 2;

  logic fclk = 1'b0;
  logic rst_n = 1'b0;
  logic slow;
  int   n_chk = 0;
  int   n_err = 0;

  reaper_exec_ctrl_if bus ();

  reaper_exec_ctrl #(.DIV(DIV)) dut (
    .Fast_Clock  (fclk),
    .Raw_Reset_I (rst_n),
    .Slow_Clock  (slow),
    .bus         (bus.master)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Control vector order, MSB first:
  // RW ASRC LIMM MW M2R BR JR JI SEN SWR IOEN IOSEL HLT CTX
  function automatic logic [13:0] ctl_of(
      input bit rw, asrc, limm, mw, m2r, br, jr,
      input bit ji, sen, swr, ioen, iosel, hlt, ctx);
    return {rw, asrc, limm, mw, m2r, br, jr,
            ji, sen, swr, ioen, iosel, hlt, ctx};
  endfunction

  // Reference decode: {alu_op, controls}.
  function automatic logic [18:0] ref_dec(input int o);
    logic [13:0] c = '0;
    int a = 0;
    if (o >= 1 && o <= 18) begin
      c = ctl_of(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      a = o - 1;
    end else if (o >= 33 && o <= 50) begin
      c = ctl_of(1,1,0,0,0,0,0,0,0,0,0,0,0,0);
      a = o - 33;
    end else begin
      case (o)
        19: begin
          c = ctl_of(1,1,1,0,0,0,0,0,0,0,0,0,0,0);
          a = 18;
        end
        20: c = ctl_of(1,1,0,0,1,0,0,0,0,0,0,0,0,0);
        21: c = ctl_of(0,1,0,1,0,0,0,0,0,0,0,0,0,0);
        22, 23, 24, 25: begin
          c = ctl_of(0,0,0,0,0,1,0,0,0,0,0,0,0,0);
          a = (o == 25) ? 16 : 12 + (o - 22);
        end
        26: c = ctl_of(0,0,0,0,0,0,1,0,0,0,0,0,0,0);
        27: c = ctl_of(0,0,1,0,0,0,0,1,0,0,0,0,0,0);
        28: c = ctl_of(0,0,1,0,0,0,0,1,1,1,0,0,0,0);
        29: c = ctl_of(0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        30: c = ctl_of(1,0,0,0,0,0,0,0,0,0,1,0,0,0);
        31: c = ctl_of(0,0,0,0,0,0,0,0,0,0,1,1,0,0);
        32: c = ctl_of(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        63: c = ctl_of(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
        default: ;
      endcase
    end
    return {5'(a), c};
  endfunction

  // Reference ALU on 64-bit integers: {True, Result}.
  function automatic logic [32:0] ref_alu(
      input int op, input logic [31:0] a,
      input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint r = 0;
    longint p2 = longint'(1) << b[4:0];
    bit t = 0;
    case (op)
      0:  r = sa + sb;
      1:  r = sa - sb;
      2:  r = sa * sb;
      3:  r = (sb == 0) ? 0 : sa / sb;
      4:  r = (sb == 0) ? 0 : sa % sb;
      5:  r = longint'(a & b);
      6:  r = longint'(a | b);
      7:  r = longint'(a ^ b);
      8:  r = -1 - sa;
      9:  r = ua * p2;
      10: r = ua / p2;
      11: r = (sa - ((sa % p2 + p2) % p2)) / p2;
      12: t = (sa == sb);
      13: t = (sa != sb);
      14: t = (sa < sb);
      15: t = (sa <= sb);
      16: t = (sa > sb);
      17: t = (sa >= sb);
      18: r = sb;
      default: r = 0;
    endcase
    if (op >= 12 && op <= 17) r = longint'(t);
    return {t, r[31:0]};
  endfunction

  function automatic logic [13:0] dut_ctl();
    return {bus.Reg_Write, bus.ALU_Src,
            bus.Long_Imm, bus.Mem_Write,
            bus.Mem_To_Reg, bus.Branch,
            bus.Jump_R, bus.Jump_I,
            bus.Stack_Enable, bus.Stack_Write,
            bus.IO_Enable, bus.IO_Selection,
            bus.Halt, bus.Change_Context};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'($urandom_range(0, 40));
      1: v = -32'($urandom_range(0, 40));
      2: v = 32'h8000_0000;
      3: v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic apply(input int o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input string tag);
    logic [18:0] d;
    logic [32:0] e;
    bus.Opcode  = 6'(o);
    bus.Input_1 = a;
    bus.Input_2 = b;
    #1;
    d = ref_dec(o);
    e = ref_alu(int'(d[18:14]), a, b);
    chk({tag, "_ctl"}, 64'(dut_ctl()), 64'(d[13:0]));
    chk({tag, "_aop"}, 64'(bus.ALU_Op), 64'(d[18:14]));
    chk({tag, "_res"}, 64'(bus.Result), 64'(e[31:0]));
    chk({tag, "_true"}, 64'(bus.True), 64'(e[32]));
  endtask

  task automatic alu_dir(input int o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] r,
                         input bit t, input string tag);
    bus.Opcode  = 6'(o);
    bus.Input_1 = a;
    bus.Input_2 = b;
    #1;
    chk({tag, "_res"}, 64'(bus.Result), 64'(r));
    chk({tag, "_true"}, 64'(bus.True), 64'(t));
  endtask

  task automatic run_div(input int cycles, input string tag);
    for (int n = 1; n <= cycles; n++) begin
      @(posedge fclk);
      #1;
      chk(tag, 64'(slow), 64'((n / DIV) % 2));
    end
  endtask

  initial begin
    bus.Opcode  = 6'h00;
    bus.Input_1 = '0;
    bus.Input_2 = '0;
    #2;
    chk("rst_slow", 64'(slow), 64'd0);
    apply(6'h3F, 32'd3, 32'd4, "rst_dec");
    @(negedge fclk);
    rst_n = 1'b1;
    run_div(13, "div_run");

    begin
      int k = 0;
      while (slow !== 1'b1 && k < 20) begin
        @(posedge fclk);
        #1;
        k++;
      end
      chk("div_high_seen", 64'(slow), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("div_async_rst", 64'(slow), 64'd0);
    @(posedge fclk);
    #1;
    chk("div_held_rst", 64'(slow), 64'd0);
    @(negedge fclk);
    rst_n = 1'b1;
    run_div(6, "div_rerun");

    for (int o = 0; o < 64; o++)
      apply(o, pick(), pick(), $sformatf("sweep%0h", o));
    apply(6'h3A, 32'h1234, 32'h5678, "undef3a");

    alu_dir(6'h01, 32'h7FFF_FFFF, 32'd1,
            32'h8000_0000, 0, "add_ovf");
    alu_dir(6'h02, 32'd0, 32'd1,
            32'hFFFF_FFFF, 0, "sub_wrap");
    alu_dir(6'h04, -32'd7, 32'd2, -32'd3, 0, "div_trunc");
    alu_dir(6'h05, -32'd7, 32'd2, -32'd1, 0, "mod_sign");
    alu_dir(6'h04, 32'd9, 32'd0, 32'd0, 0, "div_zero");
    alu_dir(6'h05, 32'd9, 32'd0, 32'd0, 0, "mod_zero");
    alu_dir(6'h04, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 0, "div_min");
    alu_dir(6'h0C, 32'h8000_0000, 32'd33,
            32'hC000_0000, 0, "sra33");
    alu_dir(6'h0B, 32'h8000_0000, 32'd33,
            32'h4000_0000, 0, "srl33");
    alu_dir(6'h0F, 32'hFFFF_FFFF, 32'd1,
            32'd1, 1, "lt");
    alu_dir(6'h12, 32'hFFFF_FFFF, 32'd1,
            32'd0, 0, "ge");
    alu_dir(6'h01, 32'd5, 32'd5, 32'd10, 0, "add_true");

    for (int i = 0; i < 400; i++)
      apply(int'($urandom_range(0, 63)), pick(), pick(),
            "rand");

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
